// File: rtl/ask_pkg.sv
// Shared types and helpers for the ASK receive path.
package ask_pkg;

  // ADC/DAC sample width used across the ASK modulator and demodulator.
  localparam int ADC_W = 12;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Window sum width: a full window of maximum samples can never overflow it.
  function automatic int acc_width(input int in_w, input int spb);
    return in_w + $clog2(spb);
  endfunction

endpackage

// File: rtl/ask_window_integrator.sv
// Bit-window integrator: accumulates accepted samples and flags the window's last sample.
module ask_window_integrator
  import ask_pkg::*;
#(
  parameter int INPUT_WIDTH     = ADC_W,
  parameter int SAMPLES_PER_BIT = 64,
  localparam int ACC_W          = acc_width(INPUT_WIDTH, SAMPLES_PER_BIT),
  localparam int CNT_W          = $clog2(SAMPLES_PER_BIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [ACC_W-1:0]       sum_o,
  output logic                   eow_o
);

  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  // While cleared, an accepted sample starts a fresh window as its sample 1.
  always_comb begin
    acc_base = clear_i ? '0 : acc_q;
    cnt_base = clear_i ? '0 : cnt_q;
    sum_o    = acc_base + ACC_W'(data_i);
    eow_o    = en_i && (cnt_base == CNT_W'(SAMPLES_PER_BIT - 1));
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    if (eow_o) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ask_demod.sv
// On-off-keyed carrier demodulator: window integration, threshold decision, lock tracking.
// Optional amplitude output enabled by defining ASK_DEMOD_AMP_OUT_EN.
module ask_demod
  import ask_pkg::*;
#(
  parameter int INPUT_WIDTH     = ADC_W,
  parameter int SAMPLES_PER_BIT = 64,
  parameter int THRESHOLD       = 1024,
  parameter int IDLE_BITS       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [INPUT_WIDTH-1:0] adc_in,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   locked
`ifdef ASK_DEMOD_AMP_OUT_EN
  ,
  output logic [INPUT_WIDTH-1:0] amp_out
`endif
);

  localparam int ACC_W = acc_width(INPUT_WIDTH, SAMPLES_PER_BIT);
  localparam int ZW    = $clog2(IDLE_BITS + 1);
  localparam logic [INPUT_WIDTH:0] TH_SAMPLE = (INPUT_WIDTH + 1)'(THRESHOLD);
  localparam logic [ACC_W:0]       TH_SUM    = (ACC_W + 1)'(THRESHOLD * SAMPLES_PER_BIT);

  state_e           state_q, state_d;
  logic             hunt, en, eow, trigger, bit_d, last_zero;
  logic [ACC_W-1:0] sum;
  logic             bit_q, bit_valid_q;
  logic [ZW-1:0]    zrun_q;

  assign trigger   = sample_valid && ({1'b0, adc_in} >= TH_SAMPLE);
  assign bit_d     = ({1'b0, sum} >= TH_SUM);
  assign last_zero = eow && !bit_d && (zrun_q == ZW'(IDLE_BITS - 1));

  ask_window_integrator #(
    .INPUT_WIDTH     (INPUT_WIDTH),
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
  ) u_integ (
    .clk     (clk),
    .rst     (rst),
    .clear_i (hunt),
    .en_i    (en),
    .data_i  (adc_in),
    .sum_o   (sum),
    .eow_o   (eow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (trigger) state_d = TRACK;
      TRACK:   if (last_zero) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  // In HUNT only a trigger sample enters the window; in TRACK every valid sample does.
  always_comb begin
    hunt   = (state_q == HUNT);
    en     = hunt ? trigger : sample_valid;
    locked = !hunt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      zrun_q      <= '0;
    end else begin
      bit_valid_q <= eow;
      if (eow) begin
        bit_q <= bit_d;
        if (bit_d || last_zero) zrun_q <= '0;
        else                    zrun_q <= zrun_q + ZW'(1);
      end
    end
  end

  assign bit_out   = bit_q;
  assign bit_valid = bit_valid_q;

`ifdef ASK_DEMOD_AMP_OUT_EN
  logic [INPUT_WIDTH-1:0] amp_q;

  // Mean sample amplitude of the window just decided.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      amp_q <= '0;
    else if (eow) amp_q <= sum[ACC_W-1 -: INPUT_WIDTH];
  end

  assign amp_out = amp_q;
`endif

endmodule

// File: tb/tb_ask_demod.sv
// Bench for ask_demod: directed vector table, hand sequences, randomized run against a window model.
module tb_ask_demod;

  localparam int SPB  = 8;
  localparam int TH   = 1024;
  localparam int IDLE = 4;
  localparam int W    = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic sample_valid;
  logic [W-1:0] adc_in;
  logic bit_out, bit_valid, locked;
`ifdef ASK_DEMOD_AMP_OUT_EN
  logic [W-1:0] amp_out;
`endif

  always #5 clk = ~clk;

  ask_demod #(
    .INPUT_WIDTH     (W),
    .SAMPLES_PER_BIT (SPB),
    .THRESHOLD       (TH),
    .IDLE_BITS       (IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .adc_in       (adc_in),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .locked       (locked)
`ifdef ASK_DEMOD_AMP_OUT_EN
    ,
    .amp_out      (amp_out)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // scoreboard and reference model state
  logic [0:0] exp_q[$];
  int strobes[$];
  int strobe_bits[$];
  bit m_locked, m_bit, m_valid;
  int m_zeros;
  int m_win[$];

  typedef struct {
    logic         v;
    logic [W-1:0] adc;
    logic         ev;
    logic         eb;
    logic         el;
  } vec_t;

  vec_t tbl[12];
  int sine_t[8] = '{2048, 3495, 4095, 3495, 2048, 600, 0, 600};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_bit    = 0;
    m_valid  = 0;
    m_zeros  = 0;
    m_win.delete();
    exp_q.delete();
  endtask

  // A window is the trigger sample plus the following accepted samples, SPB in all.
  task automatic model_accept(input logic v, input int a);
    m_valid = 0;
    if (!v) return;
    if (!m_locked) begin
      if (a >= TH) begin
        m_locked = 1;
        m_win.push_back(a);
      end
    end else begin
      m_win.push_back(a);
    end
    if (m_win.size() == SPB) begin
      int s;
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_bit   = (s >= TH * SPB);
      m_valid = 1;
      exp_q.push_back(m_bit);
      m_zeros = m_bit ? 0 : m_zeros + 1;
      if (m_zeros == IDLE) begin
        m_locked = 0;
        m_zeros  = 0;
      end
      m_win.delete();
    end
  endtask

  task automatic check_outputs();
    chk("bit_valid", bit_valid, m_valid);
    chk("locked", locked, m_locked);
    chk("bit_out", bit_out, m_bit);
    if (bit_valid) begin
      strobes.push_back(cyc);
      strobe_bits.push_back(bit_out);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_strobe: got unexpected strobe bit %0d expected none (cycle %0d)", bit_out, cyc);
      end else if (bit_out != exp_q[0]) begin
        n_errors++;
        $display("FAIL sb_bit: got %0d expected %0d (cycle %0d)", bit_out, exp_q[0], cyc);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  endtask

  // driver: one clock with the given inputs, then compare against the model
  task automatic step(input logic v, input int a);
    sample_valid = v;
    adc_in       = W'(a);
    @(posedge clk);
    model_accept(v, a);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic async_reset(input string tag);
    sample_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk({tag, "_bit_out"}, bit_out, 0);
    chk({tag, "_bit_valid"}, bit_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_strobes();
    strobes.delete();
    strobe_bits.delete();
  endtask

  task automatic check_strobes(input string tag, input int n, input int gap, input int b0,
                               input int b1, input int b2, input int b3);
    int eb[4];
    eb = '{b0, b1, b2, b3};
    chk({tag, "_count"}, strobes.size(), n);
    for (int i = 0; i < strobes.size() && i < 4; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), strobe_bits[i], eb[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), strobes[i] - strobes[i-1], gap);
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    adc_in       = '0;
    model_reset();

    // directed vectors: HUNT threshold then a single '1' window
    for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 12'd1023, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 12'd1024, 1'b0, 1'b0, 1'b1};
    for (int i = 4; i < 10; i++) tbl[i] = '{1'b1, 12'd2048, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 12'd2048, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 12'd0, 1'b0, 1'b1, 1'b1};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].adc);
      chk($sformatf("tbl%0d_valid", i), bit_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_bit", i), bit_out, tbl[i].eb);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].el);
    end

    async_reset("arst");

    // sine, zeros, sine, sine back to back
    clear_strobes();
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < SPB; k++) step(1'b1, (w == 1) ? 0 : sine_t[k]);
    check_strobes("pattern", 4, SPB, 1, 0, 1, 1);

    // IDLE zero windows drop lock; further zeros produce nothing
    clear_strobes();
    for (int k = 0; k < IDLE * SPB; k++) step(1'b1, 0);
    check_strobes("lockloss", 4, SPB, 0, 0, 0, 0);
    chk("lockloss_locked", locked, 0);
    clear_strobes();
    for (int k = 0; k < 2 * SPB; k++) step(1'b1, 0);
    chk("idle_strobes", strobes.size(), 0);

    // 50% stall: junk on adc_in while sample_valid is low
    clear_strobes();
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < SPB; k++) begin
        step(1'b1, (w == 1) ? 0 : sine_t[k]);
        step(1'b0, $urandom_range(0, 4095));
      end
    check_strobes("stall", 3, 2 * SPB, 1, 0, 1, 0);
    chk("stall_locked", locked, 1);

    // reset after sample 5 of a window discards it
    for (int k = 0; k < 5; k++) step(1'b1, 2048);
    async_reset("midrst");
    clear_strobes();
    for (int k = 0; k < 10; k++) step(1'b1, 500);
    chk("midrst_strobes", strobes.size(), 0);
    chk("midrst_locked", locked, 0);

    // randomized run
    for (int blk = 0; blk < 80; blk++) begin
      int lvl;
      case ($urandom_range(0, 2))
        0:       lvl = 0;
        1:       lvl = 900;
        default: lvl = 4095;
      endcase
      for (int k = 0; k < SPB; k++) step($urandom_range(0, 3) != 0, $urandom_range(0, lvl));
    end

    for (int k = 0; k < 3; k++) step(1'b0, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
